// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character LCD controller: power-up wait, init sequence, then a valid/ready op port.
// Optional macro LCD_AUTOWRAP_EN: a char in the last column is followed by a move to the next row.
module lcd_hd44780_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int BUS_4BIT   = 0,
  parameter int ROWS       = 2,
  parameter int COLS       = 16,
  parameter int POWERUP_US = 20000,
  parameter int EN_US      = 1,
  parameter int CMD_US     = 50,
  parameter int CLR_US     = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [1:0] op_code,
  input  logic [7:0] op_data,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic       init_done,
  output logic [1:0] cur_row,
  output logic [5:0] cur_col,
  output logic [2:0] dbg_state
);

  localparam int US_RAW  = CLK_HZ / 1000000;
  localparam int US_CYC  = (US_RAW < 1) ? 1 : US_RAW;
  localparam int PWR_CYC = (POWERUP_US * US_CYC < 1) ? 1 : POWERUP_US * US_CYC;
  localparam int EN_CYC  = (EN_US * US_CYC < 1) ? 1 : EN_US * US_CYC;
  localparam int CMD_CYC = (CMD_US * US_CYC < 1) ? 1 : CMD_US * US_CYC;
  localparam int CLR_CYC = (CLR_US * US_CYC < 1) ? 1 : CLR_US * US_CYC;

  localparam logic [31:0] PWR_LAST  = 32'(PWR_CYC - 1);
  localparam logic [31:0] EN_LAST   = 32'(EN_CYC - 1);
  localparam logic [31:0] CMD_LAST  = 32'(CMD_CYC - 1);
  localparam logic [31:0] CLR_LAST  = 32'(CLR_CYC - 1);
  localparam logic [3:0]  INIT_LAST = (BUS_4BIT != 0) ? 4'd8 : 4'd6;
  localparam logic [2:0]  ROWS_L    = 3'(ROWS);
  localparam logic [5:0]  COLS_L    = 6'(COLS);
  localparam logic [1:0]  ROW_LAST  = 2'(ROWS - 1);
  localparam logic [5:0]  COL_LAST  = 6'(COLS - 1);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, SETUP, EN_HI, EN_LO, WAIT, WRAP
  } state_t;

  // W_NOP is a single idle cycle with no bus activity (rejected set-cursor).
  typedef enum logic [1:0] {W_CMD, W_CLR, W_NOP} wsel_t;

  // What to do with the tracked cursor once the transfer's wait finishes.
  typedef enum logic [1:0] {P_NONE, P_CHAR, P_SETCUR, P_HOME} post_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  xb_q, xb_d;
  logic        xrs_q, xrs_d;
  logic        xsingle_q, xsingle_d;
  logic        xlo_q, xlo_d;
  wsel_t       wsel_q, wsel_d;
  post_t       post_q, post_d;
  logic [1:0]  trow_q, trow_d;
  logic [5:0]  tcol_q, tcol_d;
  logic [1:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic        done_q, done_d;
  logic        on_q;

  logic [8:0]  ent;
  logic [1:0]  nxt_row;
  logic        in_range;
  logic [31:0] wait_last;
  logic        in_xfer;
  logic [3:0]  nib;

  function automatic logic [6:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    row_base = 7'h00;
      2'd1:    row_base = 7'h40;
      2'd2:    row_base = 7'(COLS);
      default: row_base = 7'(64 + COLS);
    endcase
  endfunction

  // {single_nibble, byte}; single-nibble entries only exist on the 4-bit bus.
  function automatic logic [8:0] init_entry(input logic [3:0] idx);
    if (BUS_4BIT != 0) begin
      case (idx)
        4'd0, 4'd1, 4'd2: init_entry = {1'b1, 8'h30};
        4'd3:             init_entry = {1'b1, 8'h20};
        4'd4:             init_entry = {1'b0, 8'h28};
        4'd5:             init_entry = {1'b0, 8'h08};
        4'd6:             init_entry = {1'b0, 8'h01};
        4'd7:             init_entry = {1'b0, 8'h06};
        default:          init_entry = {1'b0, 8'h0C};
      endcase
    end else begin
      case (idx)
        4'd0, 4'd1, 4'd2: init_entry = {1'b0, 8'h38};
        4'd3:             init_entry = {1'b0, 8'h08};
        4'd4:             init_entry = {1'b0, 8'h01};
        4'd5:             init_entry = {1'b0, 8'h06};
        default:          init_entry = {1'b0, 8'h0C};
      endcase
    end
  endfunction

  // The high nibble of a full 4-bit byte always waits CMD; the selector applies to the final write.
  always_comb begin
    wait_last = CMD_LAST;
    if (wsel_q == W_NOP)
      wait_last = 32'd0;
    else if ((BUS_4BIT != 0) && !xsingle_q && !xlo_q)
      wait_last = CMD_LAST;
    else if (wsel_q == W_CLR)
      wait_last = CLR_LAST;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    idx_d     = idx_q;
    xb_d      = xb_q;
    xrs_d     = xrs_q;
    xsingle_d = xsingle_q;
    xlo_d     = xlo_q;
    wsel_d    = wsel_q;
    post_d    = post_q;
    trow_d    = trow_q;
    tcol_d    = tcol_q;
    row_d     = row_q;
    col_d     = col_q;
    done_d    = done_q;
    ent       = init_entry(idx_q);
    nxt_row   = (row_q == ROW_LAST) ? 2'd0 : row_q + 2'd1;
    in_range  = ({1'b0, op_data[7:6]} < ROWS_L) && (op_data[5:0] < COLS_L);

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d = INIT;
          cnt_d   = 32'd0;
        end
      end
      INIT: begin
        xb_d      = ent[7:0];
        xrs_d     = 1'b0;
        xsingle_d = ent[8];
        xlo_d     = 1'b0;
        wsel_d    = (ent[7:0] == 8'h01) ? W_CLR : W_CMD;
        post_d    = P_NONE;
        state_d   = SETUP;
        cnt_d     = 32'd0;
      end
      IDLE: begin
        cnt_d = 32'd0;
        if (op_valid && op_ready) begin
          xsingle_d = 1'b0;
          xlo_d     = 1'b0;
          xrs_d     = 1'b0;
          wsel_d    = W_CMD;
          post_d    = P_NONE;
          state_d   = SETUP;
          case (op_code)
            2'b00: begin
              xb_d   = op_data;
              xrs_d  = 1'b1;
              post_d = P_CHAR;
            end
            2'b01: begin
              xb_d   = {1'b1, row_base(op_data[7:6]) + {1'b0, op_data[5:0]}};
              post_d = P_SETCUR;
              trow_d = op_data[7:6];
              tcol_d = op_data[5:0];
              if (!in_range) begin
                wsel_d  = W_NOP;
                post_d  = P_NONE;
                state_d = WAIT;
              end
            end
            2'b10: begin
              xb_d   = 8'h01;
              wsel_d = W_CLR;
              post_d = P_HOME;
            end
            default: begin
              xb_d   = op_data;
              wsel_d = ((op_data == 8'h01) || (op_data == 8'h02)) ? W_CLR : W_CMD;
            end
          endcase
        end
      end
      SETUP: begin
        state_d = EN_HI;
        cnt_d   = 32'd0;
      end
      EN_HI: begin
        if (cnt_q == EN_LAST) begin
          state_d = EN_LO;
          cnt_d   = 32'd0;
        end
      end
      EN_LO: begin
        state_d = WAIT;
        cnt_d   = 32'd0;
      end
      WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d   = 32'd0;
          state_d = IDLE;
          if (wsel_q == W_NOP) begin
            state_d = IDLE;
          end else if ((BUS_4BIT != 0) && !xsingle_q && !xlo_q) begin
            xlo_d   = 1'b1;
            state_d = SETUP;
          end else if (!done_q) begin
            if (idx_q == INIT_LAST) begin
              done_d = 1'b1;
              row_d  = 2'd0;
              col_d  = 6'd0;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = INIT;
            end
          end else begin
            case (post_q)
              P_CHAR: begin
                if (col_q == COL_LAST) begin
`ifdef LCD_AUTOWRAP_EN
                  state_d = WRAP;
`else
                  state_d = IDLE;
`endif
                end else begin
                  col_d = col_q + 6'd1;
                end
              end
              P_SETCUR: begin
                row_d = trow_q;
                col_d = tcol_q;
              end
              P_HOME: begin
                row_d = 2'd0;
                col_d = 6'd0;
              end
              default: ;
            endcase
          end
        end
      end
      WRAP: begin
        xb_d      = {1'b1, row_base(nxt_row)};
        xrs_d     = 1'b0;
        xsingle_d = 1'b0;
        xlo_d     = 1'b0;
        wsel_d    = W_CMD;
        post_d    = P_SETCUR;
        trow_d    = nxt_row;
        tcol_d    = 6'd0;
        state_d   = SETUP;
        cnt_d     = 32'd0;
      end
      default: begin
        state_d = PWR_WAIT;
        cnt_d   = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PWR_WAIT;
      cnt_q     <= 32'd0;
      idx_q     <= 4'd0;
      xb_q      <= 8'd0;
      xrs_q     <= 1'b0;
      xsingle_q <= 1'b0;
      xlo_q     <= 1'b0;
      wsel_q    <= W_CMD;
      post_q    <= P_NONE;
      trow_q    <= 2'd0;
      tcol_q    <= 6'd0;
      row_q     <= 2'd0;
      col_q     <= 6'd0;
      done_q    <= 1'b0;
      on_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      xb_q      <= xb_d;
      xrs_q     <= xrs_d;
      xsingle_q <= xsingle_d;
      xlo_q     <= xlo_d;
      wsel_q    <= wsel_d;
      post_q    <= post_d;
      trow_q    <= trow_d;
      tcol_q    <= tcol_d;
      row_q     <= row_d;
      col_q     <= col_d;
      done_q    <= done_d;
      on_q      <= 1'b1;
    end
  end

  // Op port: an op is taken on any cycle with op_valid && op_ready; op_ready is high only in
  // IDLE after init, so it drops the cycle after an accept, and op_* are read only on that cycle.
  assign op_ready  = (state_q == IDLE) && done_q;
  assign in_xfer   = (state_q == SETUP) || (state_q == EN_HI) || (state_q == EN_LO);
  assign nib       = xlo_q ? xb_q[3:0] : xb_q[7:4];
  assign lcd_data  = !in_xfer ? 8'h00 : ((BUS_4BIT != 0) ? {nib, 4'h0} : xb_q);
  assign lcd_rs    = in_xfer && xrs_q;
  assign lcd_en    = (state_q == EN_HI);
  assign lcd_rw    = 1'b0;
  assign lcd_on    = on_q;
  assign init_done = done_q;
  assign cur_row   = row_q;
  assign cur_col   = col_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: an 8-bit and a 4-bit instance, random ops, reference model and
// expected-transfer queues checked by a bus monitor.
module tb_lcd_hd44780_ctrl;
  localparam int CLK_HZ = 4000000, POWERUP_US = 20, EN_US = 1, CMD_US = 2, CLR_US = 5, US = 4;
  localparam int R8 = 2, C8 = 16, R4 = 4, C4 = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] op_code = 2'd0;
  logic [7:0] op_data = 8'd0;
  logic op_valid8 = 1'b0, op_valid4 = 1'b0;
  logic rdy8, rdy4, rs8, rs4, en8, en4, rw8, rw4, on8, on4, done8, done4;
  logic [7:0] data8, data4;
  logic [1:0] row8, row4;
  logic [5:0] col8, col4;
  logic [2:0] dbg8, dbg4;

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(.CLK_HZ(CLK_HZ), .BUS_4BIT(0), .ROWS(R8), .COLS(C8), .POWERUP_US(POWERUP_US),
    .EN_US(EN_US), .CMD_US(CMD_US), .CLR_US(CLR_US)) u8 (
    .clk(clk), .rst(rst), .op_valid(op_valid8), .op_ready(rdy8), .op_code(op_code),
    .op_data(op_data), .lcd_data(data8), .lcd_rs(rs8), .lcd_en(en8), .lcd_rw(rw8),
    .lcd_on(on8), .init_done(done8), .cur_row(row8), .cur_col(col8), .dbg_state(dbg8));

  lcd_hd44780_ctrl #(.CLK_HZ(CLK_HZ), .BUS_4BIT(1), .ROWS(R4), .COLS(C4), .POWERUP_US(POWERUP_US),
    .EN_US(EN_US), .CMD_US(CMD_US), .CLR_US(CLR_US)) u4 (
    .clk(clk), .rst(rst), .op_valid(op_valid4), .op_ready(rdy4), .op_code(op_code),
    .op_data(op_data), .lcd_data(data4), .lcd_rs(rs4), .lcd_en(en4), .lcd_rw(rw4),
    .lcd_on(on4), .init_done(done4), .cur_row(row4), .cur_col(col4), .dbg_state(dbg4));

  logic [8:0] exp_q8[$];
  logic [8:0] exp_q4[$];
  int tests = 0, fails = 0;
  int cyc = 0, rel_cyc = 0;
  int first_rise[2];
  bit prev_en[2];
  int width[2];
  int mrow[2], mcol[2];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rows_of(input int d); return d ? R4 : R8; endfunction
  function automatic int cols_of(input int d); return d ? C4 : C8; endfunction

  function automatic int base_of(input int r, input int cols);
    case (r)
      0: return 'h00;
      1: return 'h40;
      2: return cols;
      default: return 'h40 + cols;
    endcase
  endfunction

  // Busy cycles seen on op_ready for one write: setup + strobe + hold + wait, per nibble.
  function automatic int xfer_cycles(input int d, input bit long_wait);
    int one, w;
    one = EN_US * US + 2;
    w = long_wait ? CLR_US * US : CMD_US * US;
    return d ? (one + CMD_US * US) + (one + w) : one + w;
  endfunction

  task automatic push_x(input int d, input bit rs, input logic [7:0] b, input bit single);
    if (d == 0) exp_q8.push_back({rs, b});
    else begin
      exp_q4.push_back({rs, b[7:4], 4'h0});
      if (!single) exp_q4.push_back({rs, b[3:0], 4'h0});
    end
  endtask

  task automatic model_init(input int d);
    logic [7:0] s8[7];
    logic [7:0] s4[5];
    s8 = '{8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    s4 = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
    if (d == 0) begin
      for (int i = 0; i < 7; i++) push_x(0, 1'b0, s8[i], 1'b0);
    end else begin
      for (int i = 0; i < 3; i++) push_x(1, 1'b0, 8'h30, 1'b1);
      push_x(1, 1'b0, 8'h20, 1'b1);
      for (int i = 0; i < 5; i++) push_x(1, 1'b0, s4[i], 1'b0);
    end
    mrow[d] = 0;
    mcol[d] = 0;
  endtask

  task automatic model_op(input int d, input logic [1:0] code, input logic [7:0] data,
                          output int busy);
    int rows, cols, r, c, nr;
    logic [7:0] a;
    rows = rows_of(d);
    cols = cols_of(d);
    busy = 0;
    case (code)
      2'b00: begin
        busy = xfer_cycles(d, 1'b0);
        push_x(d, 1'b1, data, 1'b0);
        if (mcol[d] == cols - 1) begin
`ifdef LCD_AUTOWRAP_EN
          busy = -1;
          nr = (mrow[d] + 1) % rows;
          a = 8'(base_of(nr, cols)) | 8'h80;
          push_x(d, 1'b0, a, 1'b0);
          mrow[d] = nr;
          mcol[d] = 0;
`endif
        end else mcol[d]++;
      end
      2'b01: begin
        r = int'(data[7:6]);
        c = int'(data[5:0]);
        if (r < rows && c < cols) begin
          busy = xfer_cycles(d, 1'b0);
          a = 8'(base_of(r, cols) + c) | 8'h80;
          push_x(d, 1'b0, a, 1'b0);
          mrow[d] = r;
          mcol[d] = c;
        end else busy = 1;
      end
      2'b10: begin
        busy = xfer_cycles(d, 1'b1);
        push_x(d, 1'b0, 8'h01, 1'b0);
        mrow[d] = 0;
        mcol[d] = 0;
      end
      default: begin
        busy = xfer_cycles(d, (data == 8'h01) || (data == 8'h02));
        push_x(d, 1'b0, data, 1'b0);
      end
    endcase
  endtask

  // ---------------- bus monitor ----------------
  task automatic mon(input int d);
    logic en;
    logic [8:0] got, exp;
    en = d ? en4 : en8;
    got = d ? {rs4, data4} : {rs8, data8};
    if (!rst) begin
      prev_en[d] = 1'b0;
      width[d] = 0;
      return;
    end
    if (en) begin
      if (!prev_en[d]) begin
        if (first_rise[d] < 0) first_rise[d] = cyc - rel_cyc;
        tests++;
        if ((d ? exp_q4.size() : exp_q8.size()) == 0) begin
          fails++;
          $display("FAIL u%0d xfer_unexpected: got rs/data %0h, expected no transfer", d ? 4 : 8, got);
        end else begin
          tests--;
          exp = d ? exp_q4.pop_front() : exp_q8.pop_front();
          check(d ? "u4 xfer rs/data" : "u8 xfer rs/data", 32'(got), 32'(exp));
        end
      end
      width[d]++;
    end else if (prev_en[d]) begin
      check(d ? "u4 en width" : "u8 en width", 32'(width[d]), 32'(EN_US * US));
      width[d] = 0;
    end
    prev_en[d] = en;
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    int n;
    rst = 1'b0;
    exp_q8.delete();
    exp_q4.delete();
    repeat (3) @(negedge clk);
    first_rise[0] = -1;
    first_rise[1] = -1;
    model_init(0);
    model_init(1);
    rst = 1'b1;
    rel_cyc = cyc;
    n = 0;
    while (!(done8 && done4) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("init completes", 32'(n < 3000), 32'd1);
    check("u8 powerup quiet", 32'(first_rise[0] >= 80), 32'd1);
    check("u4 powerup quiet", 32'(first_rise[1] >= 80), 32'd1);
    check("u8 ready after init", 32'(rdy8), 32'd1);
    check("u4 ready after init", 32'(rdy4), 32'd1);
    check("u8 init queue drained", 32'(exp_q8.size()), 32'd0);
    check("u4 init queue drained", 32'(exp_q4.size()), 32'd0);
    check("u8 cursor after init", 32'({row8, col8}), 32'd0);
    check("u4 cursor after init", 32'({row4, col4}), 32'd0);
  endtask

  task automatic send_op(input int d, input logic [1:0] code, input logic [7:0] data);
    int n, busy;
    @(negedge clk);
    op_code = code;
    op_data = data;
    n = 0;
    while (!(d ? rdy4 : rdy8) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      check("ready before op", 32'd0, 32'd1);
      return;
    end
    if (d) op_valid4 = 1'b1;
    else op_valid8 = 1'b1;
    @(posedge clk);
    #1;
    op_valid8 = 1'b0;
    op_valid4 = 1'b0;
    model_op(d, code, data, busy);
    n = 0;
    @(negedge clk);
    while (!(d ? rdy4 : rdy8) && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("ready returns", 32'(n < 5000), 32'd1);
    if (busy >= 0) check(d ? "u4 busy cycles" : "u8 busy cycles", 32'(n), 32'(busy));
    check(d ? "u4 cursor" : "u8 cursor", 32'(d ? {row4, col4} : {row8, col8}),
          32'({2'(mrow[d]), 6'(mcol[d])}));
  endtask

  task automatic rand_op(input int d);
    logic [1:0] code;
    logic [7:0] data;
    logic [7:0] raws[9];
    raws = '{8'h01, 8'h02, 8'h06, 8'h0C, 8'h0E, 8'h10, 8'h14, 8'h18, 8'h1C};
    code = 2'($urandom_range(0, 3));
    case (code)
      2'b00: data = 8'($urandom_range(32, 126));
      2'b01: data = {2'($urandom_range(0, 3)), 6'($urandom_range(0, cols_of(d) + 3))};
      2'b10: data = 8'h00;
      default: data = raws[$urandom_range(0, 8)];
    endcase
    send_op(d, code, data);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    first_rise[0] = -1;
    first_rise[1] = -1;
    repeat (2) @(negedge clk);
    check("u8 outputs in reset", 32'({rdy8, en8, rs8, rw8, on8, done8, row8, col8, data8}), 32'd0);
    check("u4 outputs in reset", 32'({rdy4, en4, rs4, rw4, on4, done4, row4, col4, data4}), 32'd0);

    do_reset();
    check("u8 lcd_on", 32'(on8), 32'd1);

    // directed ops
    send_op(0, 2'b00, 8'h41);
    send_op(0, 2'b01, {2'd1, 6'd3});
    send_op(0, 2'b01, {2'd2, 6'd0});
    send_op(0, 2'b01, {2'd0, 6'd20});
    send_op(1, 2'b00, 8'h41);
    send_op(1, 2'b01, {2'd3, 6'd5});
    send_op(1, 2'b01, {2'd0, 6'd25});
    send_op(0, 2'b11, 8'h02);

    // fill row 0 and run past the last column
    send_op(0, 2'b01, 8'h00);
    repeat (17) send_op(0, 2'b00, 8'($urandom_range(32, 126)));
    send_op(1, 2'b01, {2'd3, 6'd18});
    repeat (3) send_op(1, 2'b00, 8'($urandom_range(32, 126)));

    repeat (40) rand_op(0);
    repeat (15) rand_op(1);

    // reset during the strobe of a clear
    check("u8 queue empty before abort", 32'(exp_q8.size()), 32'd0);
    check("u4 queue empty before abort", 32'(exp_q4.size()), 32'd0);
    @(negedge clk);
    op_code = 2'b10;
    op_data = 8'h00;
    op_valid8 = 1'b1;
    @(posedge clk);
    #1;
    op_valid8 = 1'b0;
    push_x(0, 1'b0, 8'h01, 1'b0);
    n = 0;
    while (!en8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("clear strobe seen", 32'(en8), 32'd1);
    rst = 1'b0;
    #1;
    check("abort en low", 32'(en8), 32'd0);
    check("abort ready low", 32'(rdy8), 32'd0);
    do_reset();

    repeat (8) rand_op(0);
    repeat (4) rand_op(1);
    repeat (20) @(negedge clk);
    check("u8 final queue empty", 32'(exp_q8.size()), 32'd0);
    check("u4 final queue empty", 32'(exp_q4.size()), 32'd0);
    check("rw tied low", 32'({rw8, rw4}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
